key_repeat: RTL and testbench

- Sits directly downstream of the button debouncer in the clock design.
- Takes the debounced button level and produces a one-cycle step pulse on each press.
- After a long hold, produces further step pulses at a fixed auto-repeat rate, used by the time-set logic to advance hours and minutes.
- Timing is measured in cycles of an external clock-enable strobe (ce), not in raw cclk cycles.

---
 rtl/key_pkg.sv | 19 +
 rtl/rise_detect.sv | 33 +++
 rtl/key_repeat.sv | 137 +++++++++++++
 tb/tb_key_repeat.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/key_pkg.sv
// ---------------------------------------------------------------------------
// key_pkg
// Shared definitions for the key auto-repeat block: FSM state type and
// encodings, plus the default hold / repeat tick counts.
// ---------------------------------------------------------------------------
package key_pkg;

    // FSM state type and encodings
    typedef logic [1:0] key_state_t;

    localparam key_state_t ST_IDLE    = 2'd0;
    localparam key_state_t ST_PRESSED = 2'd1;
    localparam key_state_t ST_REPEAT  = 2'd2;

    // Default timing, in ce ticks
    localparam int KEY_HOLD_TICKS   = 200;
    localparam int KEY_REPEAT_TICKS = 25;

endpackage : key_pkg

// File: rtl/rise_detect.sv
// ---------------------------------------------------------------------------
// rise_detect
// Detects a rising edge of the debounced button level. The previous-level
// register resets to 1 so that a button held through reset is not seen as
// a fresh press until it has been released.
//
// Ports:
//   cclk  in   system clock, rising edge
//   clr   in   synchronous active-high reset
//   btn   in   debounced button level
//   press out  high while btn=1 and the previous sampled level was 0
// ---------------------------------------------------------------------------
module rise_detect (
    input  logic cclk,
    input  logic clr,
    input  logic btn,
    output logic press
);

    logic r_btn_prev;

    // Previous button level, preset high on reset
    always_ff @(posedge cclk) begin
        if (clr) begin
            r_btn_prev <= 1'b1;
        end else begin
            r_btn_prev <= btn;
        end
    end

    assign press = btn & ~r_btn_prev;

endmodule : rise_detect

// File: rtl/key_repeat.sv
// ---------------------------------------------------------------------------
// key_repeat
// Turns a debounced button level into step pulses: one pulse on each press
// and, after the button has been held HOLD_TICKS ce ticks, further pulses
// every REPEAT_TICKS ce ticks. 'long' is high while in the repeat phase.
//
// Configuration macro: KEY_AUTOREPEAT_EN
//   defined   : step on entering the repeat phase and every REPEAT_TICKS after
//   undefined : one step per press only; 'long' still flags a long press
//
// Ports:
//   cclk in   system clock, rising edge
//   clr  in   synchronous active-high reset
//   ce   in   timebase strobe, one cclk wide
//   btn  in   debounced button level, synchronous to cclk
//   step out  registered one-cycle pulse per press / auto-repeat
//   long out  registered level, high during the repeat phase
// ---------------------------------------------------------------------------
module key_repeat
    import key_pkg::*;
#(
    parameter int HOLD_TICKS   = KEY_HOLD_TICKS,
    parameter int REPEAT_TICKS = KEY_REPEAT_TICKS,
    parameter int CNT_W        = 8
) (
    input  logic cclk,
    input  logic clr,
    input  logic ce,
    input  logic btn,
    output logic step,
    output logic long
);

`ifdef KEY_AUTOREPEAT_EN
    localparam logic C_AR_EN = 1'b1;
`else
    localparam logic C_AR_EN = 1'b0;
`endif

    localparam logic [CNT_W-1:0] C_HOLD_LAST = CNT_W'(HOLD_TICKS - 1);
    localparam logic [CNT_W-1:0] C_REP_LAST  = CNT_W'(REPEAT_TICKS - 1);
    localparam logic [CNT_W-1:0] C_CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] C_CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

    key_state_t       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_step;
    logic             r_long;

    key_state_t       w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_step_nxt;
    logic             w_long_nxt;
    logic             w_press;

    rise_detect u_rise_detect (
        .cclk  (cclk),
        .clr   (clr),
        .btn   (btn),
        .press (w_press)
    );

    // Next-state, counter and output decode; release beats a ce threshold
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_step_nxt  = 1'b0;
        w_long_nxt  = r_long;
        case (r_state)
            ST_IDLE: begin
                w_cnt_nxt  = C_CNT_ZERO;
                w_long_nxt = 1'b0;
                if (w_press) begin
                    w_state_nxt = ST_PRESSED;
                    w_step_nxt  = 1'b1;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_PRESSED: begin
                if (!btn) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = C_CNT_ZERO;
                    w_long_nxt  = 1'b0;
                end else if (ce && (r_cnt == C_HOLD_LAST)) begin
                    w_state_nxt = ST_REPEAT;
                    w_cnt_nxt   = C_CNT_ZERO;
                    w_long_nxt  = 1'b1;
                    w_step_nxt  = C_AR_EN;
                end else if (ce) begin
                    w_cnt_nxt   = r_cnt + C_CNT_ONE;
                end else begin
                    w_cnt_nxt   = r_cnt;
                end
            end
            ST_REPEAT: begin
                // Without auto-repeat the counter still cycles but never steps
                if (!btn) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = C_CNT_ZERO;
                    w_long_nxt  = 1'b0;
                end else if (ce && (r_cnt == C_REP_LAST)) begin
                    w_cnt_nxt   = C_CNT_ZERO;
                    w_step_nxt  = C_AR_EN;
                end else if (ce) begin
                    w_cnt_nxt   = r_cnt + C_CNT_ONE;
                end else begin
                    w_cnt_nxt   = r_cnt;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = C_CNT_ZERO;
                w_long_nxt  = 1'b0;
            end
        endcase
    end

    // State, counter and registered outputs
    always_ff @(posedge cclk) begin
        if (clr) begin
            r_state <= ST_IDLE;
            r_cnt   <= C_CNT_ZERO;
            r_step  <= 1'b0;
            r_long  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_step  <= w_step_nxt;
            r_long  <= w_long_nxt;
        end
    end

    assign step = r_step;
    assign long = r_long;

endmodule : key_repeat

// File: tb/tb_key_repeat.sv
// ---------------------------------------------------------------------------
// tb_key_repeat
// Scoreboard bench for key_repeat with HOLD_TICKS=4, REPEAT_TICKS=2.
// Expected {step,long} is computed from a hold-duration model when inputs
// are driven and compared after the following rising edge.
// ---------------------------------------------------------------------------
module tb_key_repeat;

    localparam int HOLD   = 4;
    localparam int REPEAT = 2;

`ifdef KEY_AUTOREPEAT_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif

    logic cclk = 1'b0;
    logic clr  = 1'b1;
    logic ce   = 1'b0;
    logic btn  = 1'b0;
    logic step;
    logic long;

    int n_checks = 0;
    int n_errors = 0;
    int cyc_no   = 0;

    logic [1:0] exp_q[$];

    // model state: ticks counts ce ticks since the press edge
    bit m_prev  = 1'b1;
    bit m_held  = 1'b0;
    int m_ticks = 0;

    key_repeat #(
        .HOLD_TICKS   (HOLD),
        .REPEAT_TICKS (REPEAT),
        .CNT_W        (8)
    ) dut (
        .cclk (cclk),
        .clr  (clr),
        .ce   (ce),
        .btn  (btn),
        .step (step),
        .long (long)
    );

    always #5 cclk = ~cclk;

    task automatic chk(input string tag, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s (cycle %0d): got %b expected %b", tag, cyc_no, act, exp);
        end
    endtask

    // Advance the model by one edge and return expected {step,long}
    function automatic logic [1:0] model(input bit c, input bit e, input bit b);
        bit es;
        bit el;
        es = 1'b0;
        if (c) begin
            m_held  = 1'b0;
            m_ticks = 0;
            m_prev  = 1'b1;
            return 2'b00;
        end
        if (!m_held) begin
            if (b && !m_prev) begin
                m_held  = 1'b1;
                m_ticks = 0;
                es      = 1'b1;
            end
        end else if (!b) begin
            m_held  = 1'b0;
            m_ticks = 0;
        end else if (e) begin
            m_ticks++;
            if (m_ticks == HOLD) es = AR;
            else if (m_ticks > HOLD && ((m_ticks - HOLD) % REPEAT) == 0) es = AR;
        end
        el     = m_held && (m_ticks >= HOLD);
        m_prev = b;
        return {es, el};
    endfunction

    task automatic cyc(input string tag, input bit c, input bit e, input bit b);
        logic [1:0] exp;
        @(negedge cclk);
        clr = c;
        ce  = e;
        btn = b;
        exp_q.push_back(model(c, e, b));
        @(posedge cclk);
        #1;
        cyc_no++;
        exp = exp_q.pop_front();
        chk({tag, ".step"}, step, exp[1]);
        chk({tag, ".long"}, long, exp[0]);
    endtask

    initial begin
        // held through reset: no step until released and pressed again
        for (int i = 0; i < 3; i++)  cyc("reset", 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 20; i++) cyc("held_thru_reset", 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++)  cyc("idle", 1'b0, 1'b1, 1'b0);

        // short press: E, E+1 high, released at E+2
        for (int i = 0; i < 2; i++)  cyc("short", 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++)  cyc("short_rel", 1'b0, 1'b1, 1'b0);

        // long hold E..E+8, released at E+9
        for (int i = 0; i < 9; i++)  cyc("hold", 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++)  cyc("hold_rel", 1'b0, 1'b1, 1'b0);

        // release exactly at the hold threshold edge
        for (int i = 0; i < 4; i++)  cyc("thr_rel", 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++)  cyc("thr_rel_lo", 1'b0, 1'b1, 1'b0);
        // a new press must still step, proving the FSM returned to idle
        for (int i = 0; i < 2; i++)  cyc("thr_repress", 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 2; i++)  cyc("thr_repress_lo", 1'b0, 1'b1, 1'b0);

        // sparse ce: one tick every 3rd cclk
        for (int i = 0; i < 24; i++) cyc("sparse_ce", 1'b0, (i % 3) == 2, 1'b1);
        for (int i = 0; i < 3; i++)  cyc("sparse_rel", 1'b0, 1'b1, 1'b0);

        // 30-cycle hold
        for (int i = 0; i < 30; i++) cyc("hold30", 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++)  cyc("hold30_rel", 1'b0, 1'b1, 1'b0);

        // reset mid-hold, then button still held: no step until re-press
        for (int i = 0; i < 6; i++)  cyc("mid_hold", 1'b0, 1'b1, 1'b1);
        cyc("mid_clr", 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++)  cyc("after_clr", 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 2; i++)  cyc("after_clr_lo", 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 2; i++)  cyc("after_clr_press", 1'b0, 1'b1, 1'b1);
        cyc("after_clr_rel", 1'b0, 1'b1, 1'b0);

        // random btn / ce mix with long runs
        for (int i = 0; i < 300; i++) begin
            bit b;
            b = ($urandom_range(0, 9) < 7);
            cyc("random", 1'b0, $urandom_range(0, 1) == 1, b);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_key_repeat
